// File: rtl/timing_generator.sv
// Master 4004 timing: divides sysclk into the clk1/clk2 quarter phases and sequences
// the eight A1..X3 subcycles, decoding phase-1/phase-2 strobes and SYNC from state.
module timing_generator #(
  parameter int CLK_DIV = 17
) (
  input  logic sysclk,
  input  logic poc,
  output logic clk1,
  output logic clk2,
  output logic a11,
  output logic a21,
  output logic a31,
  output logic m11,
  output logic m21,
  output logic x11,
  output logic x21,
  output logic x31,
  output logic a12,
  output logic a22,
  output logic a32,
  output logic m12,
  output logic m22,
  output logic x12,
  output logic x22,
  output logic x32,
  output logic sync,
  output logic m12_m22_clk1_m11_m12
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    SUB_A1 = 3'd0,
    SUB_A2 = 3'd1,
    SUB_A3 = 3'd2,
    SUB_M1 = 3'd3,
    SUB_M2 = 3'd4,
    SUB_X1 = 3'd5,
    SUB_X2 = 3'd6,
    SUB_X3 = 3'd7
  } sub_t;

  logic             r_run;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_ph;
  sub_t             r_sub;
  logic             r_x3_seen;

  logic             w_div_wrap;
  logic [7:0]       w_sub_oh;
  logic [7:0]       w_s1;
  logic [7:0]       w_s2;
  logic             w_next_lead;

  assign w_div_wrap = (r_div == DIV_LAST);

  // The release edge only arms run so the first A1 ph0 gets its full length.
  always_ff @(posedge sysclk) begin
    if (poc) begin
      r_run     <= 1'b0;
      r_div     <= '0;
      r_ph      <= 2'd0;
      r_sub     <= SUB_A1;
      r_x3_seen <= 1'b0;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else begin
      if (w_div_wrap) begin
        r_div <= '0;
        r_ph  <= r_ph + 2'd1;
        if (r_ph == 2'd3) begin
          r_sub <= sub_t'(r_sub + 3'd1);
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      if (r_sub == SUB_X3 && r_ph == 2'd2) begin
        r_x3_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    w_sub_oh        = '0;
    w_sub_oh[r_sub] = r_run;
  end

  // Phase-2 strobes trail by half a subcycle; the X3 tail into A1 only exists once
  // an X3 has actually been reached since reset.
  assign w_next_lead = w_sub_oh[0] & r_x3_seen;
  assign w_s1 = w_sub_oh;
  assign w_s2 = (w_sub_oh & {8{r_ph[1]}})
              | ({w_next_lead, w_sub_oh[7:1]} & {8{~r_ph[1]}});

  assign clk1 = r_run & (r_ph == 2'd0);
  assign clk2 = r_run & (r_ph == 2'd2);

  assign a11 = w_s1[0];
  assign a21 = w_s1[1];
  assign a31 = w_s1[2];
  assign m11 = w_s1[3];
  assign m21 = w_s1[4];
  assign x11 = w_s1[5];
  assign x21 = w_s1[6];
  assign x31 = w_s1[7];

  assign a12 = w_s2[0];
  assign a22 = w_s2[1];
  assign a32 = w_s2[2];
  assign m12 = w_s2[3];
  assign m22 = w_s2[4];
  assign x12 = w_s2[5];
  assign x22 = w_s2[6];
  assign x32 = w_s2[7];

  assign sync = w_sub_oh[7];

  assign m12_m22_clk1_m11_m12 = w_s2[3] | w_s2[4] | (clk1 & ~(w_s1[3] | w_s2[3]));

endmodule
